// File: rtl/mem_access_pkg.sv
// Shared definitions for the byte-serial MEM stage: op codes, width field, states.
package mem_access_pkg;

  localparam int unsigned OP_LEN           = 2;
  localparam int unsigned WIDTH_LEN        = 4;
  localparam int unsigned NBYTES_LEN       = 3;
  localparam int unsigned CNT_LEN          = 2;
  localparam int unsigned BUF_LEN          = 32;
  localparam int unsigned STATE_LEN        = 2;

  // width_i field positions: [2:0] byte count, [3] zero-extend
  localparam int unsigned WIDTH_NBYTES_MSB = 2;
  localparam int unsigned WIDTH_ZEXT_BIT   = 3;

  localparam logic [OP_LEN-1:0] MEMOP_NONE  = 2'd0;
  localparam logic [OP_LEN-1:0] MEMOP_LOAD  = 2'd1;
  localparam logic [OP_LEN-1:0] MEMOP_STORE = 2'd2;

  localparam logic [NBYTES_LEN-1:0] WIDTH_B = 3'd1;
  localparam logic [NBYTES_LEN-1:0] WIDTH_H = 3'd2;
  localparam logic [NBYTES_LEN-1:0] WIDTH_W = 3'd4;

  localparam logic [STATE_LEN-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_LEN-1:0] ST_ACCESS = 2'd1;
  localparam logic [STATE_LEN-1:0] ST_DONE   = 2'd2;

  // Control fields latched when an access is accepted
  typedef struct packed {
    logic [OP_LEN-1:0]     op;
    logic [NBYTES_LEN-1:0] nbytes;
    logic                  zext;
    logic                  rd_enable;
  } ctrl_t;

  function automatic logic nbytes_ok(input logic [NBYTES_LEN-1:0] n);
    return (n == WIDTH_B) || (n == WIDTH_H) || (n == WIDTH_W);
  endfunction

  function automatic logic is_mem_op(input logic [OP_LEN-1:0] op);
    return (op == MEMOP_LOAD) || (op == MEMOP_STORE);
  endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Sign/zero extension of the assembled load buffer to register width.
module mem_access_load_extend
  import mem_access_pkg::*;
#(
  parameter int unsigned REG_LEN = 32
) (
  input  logic [BUF_LEN-1:0]    data_i,
  input  logic [NBYTES_LEN-1:0] nbytes_i,
  input  logic                  zext_i,
  output logic [REG_LEN-1:0]    data_o
);

  logic [BUF_LEN-1:0] ext;
  logic               sign_b;
  logic               sign_h;

  // Replicate the top loaded bit unless zero extension is requested
  always_comb begin
    sign_b = data_i[7]  & ~zext_i;
    sign_h = data_i[15] & ~zext_i;
    ext    = data_i;
    case (nbytes_i)
      WIDTH_B: ext = {{24{sign_b}}, data_i[7:0]};
      WIDTH_H: ext = {{16{sign_h}}, data_i[15:0]};
      default: ext = data_i;
    endcase
    data_o = REG_LEN'(ext);
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: byte-serial loads/stores with pipeline stall, zero-latency pass-through.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_LEN     = 32,
  parameter int unsigned REG_LEN      = 32,
  parameter int unsigned REG_ADDR_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OP_LEN-1:0]       mem_op_i,
  input  logic [WIDTH_LEN-1:0]    width_i,
  input  logic [ADDR_LEN-1:0]     mem_addr_i,
  input  logic [REG_LEN-1:0]      rd_data_i,
  input  logic [REG_ADDR_LEN-1:0] rd_addr_i,
  input  logic                    rd_enable_i,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_LEN-1:0]     mem_addr_o,
  output logic [7:0]              mem_wdata_o,
  input  logic                    mem_ready_i,
  input  logic [7:0]              mem_rdata_i,
  output logic [REG_LEN-1:0]      rd_data_o,
  output logic [REG_ADDR_LEN-1:0] rd_addr_o,
  output logic                    rd_enable_o,
  output logic                    stall_req_o
);

  logic [STATE_LEN-1:0]    state_q, state_d;
  ctrl_t                   ctrl_q, ctrl_d;
  logic [ADDR_LEN-1:0]     addr_q, addr_d;
  logic [BUF_LEN-1:0]      wdata_q, wdata_d;
  logic [REG_ADDR_LEN-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_LEN-1:0]      cnt_q, cnt_d;
  logic [BUF_LEN-1:0]      buf_q, buf_d;

  logic                    accept;
  logic                    last_byte;
  logic [REG_LEN-1:0]      ext_data;

  assign accept    = is_mem_op(mem_op_i) && nbytes_ok(width_i[WIDTH_NBYTES_MSB:0]);
  assign last_byte = (cnt_q == CNT_LEN'(ctrl_q.nbytes - NBYTES_LEN'(1)));

  mem_access_load_extend #(
    .REG_LEN (REG_LEN)
  ) u_load_extend (
    .data_i   (buf_q),
    .nbytes_i (ctrl_q.nbytes),
    .zext_i   (ctrl_q.zext),
    .data_o   (ext_data)
  );

  // State and latch registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_addr_q <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_addr_q <= rd_addr_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
    end
  end

  // Next-state and output decode; outputs forced low while reset is asserted
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_addr_d   = rd_addr_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;

    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    rd_data_o   = '0;
    rd_addr_o   = '0;
    rd_enable_o = 1'b0;
    stall_req_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rd_data_o   = rd_data_i;
        rd_addr_o   = rd_addr_i;
        rd_enable_o = rd_enable_i;
        if (accept) begin
          stall_req_o      = 1'b1;
          rd_enable_o      = 1'b0;
          ctrl_d.op        = mem_op_i;
          ctrl_d.nbytes    = width_i[WIDTH_NBYTES_MSB:0];
          ctrl_d.zext      = width_i[WIDTH_ZEXT_BIT];
          ctrl_d.rd_enable = rd_enable_i;
          addr_d           = mem_addr_i;
          wdata_d          = BUF_LEN'(rd_data_i);
          rd_addr_d        = rd_addr_i;
          cnt_d            = '0;
          buf_d            = '0;
          state_d          = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        mem_req_o   = 1'b1;
        mem_we_o    = (ctrl_q.op == MEMOP_STORE);
        mem_addr_o  = addr_q + ADDR_LEN'(cnt_q);
        mem_wdata_o = wdata_q[{cnt_q, 3'b000} +: 8];
        stall_req_o = 1'b1;
        if (mem_ready_i) begin
          if (ctrl_q.op == MEMOP_LOAD) begin
            buf_d[{cnt_q, 3'b000} +: 8] = mem_rdata_i;
          end
          if (last_byte) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_LEN'(1);
          end
        end
      end

      ST_DONE: begin
        rd_addr_o = rd_addr_q;
        if (ctrl_q.op == MEMOP_LOAD) begin
          rd_enable_o = ctrl_q.rd_enable;
          rd_data_o   = ext_data;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!rst) begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      rd_data_o   = '0;
      rd_addr_o   = '0;
      rd_enable_o = 1'b0;
      stall_req_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: vector table, reset corner case, random traffic.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_op_i;
  logic [3:0]  width_i;
  logic [31:0] mem_addr_i;
  logic [31:0] rd_data_i;
  logic [4:0]  rd_addr_i;
  logic        rd_enable_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_ready_i;
  logic [7:0]  mem_rdata_i;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_enable_o;
  logic        stall_req_o;

  mem_access dut (
    .clk         (clk),
    .rst         (rst),
    .mem_op_i    (mem_op_i),
    .width_i     (width_i),
    .mem_addr_i  (mem_addr_i),
    .rd_data_i   (rd_data_i),
    .rd_addr_i   (rd_addr_i),
    .rd_enable_i (rd_enable_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i),
    .rd_data_o   (rd_data_o),
    .rd_addr_o   (rd_addr_o),
    .rd_enable_o (rd_enable_o),
    .stall_req_o (stall_req_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory seen by the DUT, and the reference model's view of memory
  logic [7:0] mem     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic [4:0]  ra;
    logic        en;
    int          dly;
    logic [31:0] exp_data;
    logic        exp_en;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    mem[a]     = b;
    ref_mem[a] = b;
  endtask

  // Little-endian assembly, then sign extension by arithmetic on the value
  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input logic zext);
    longint v = 0;
    logic [31:0] ai;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      v  = v + (longint'(rd_ref(ai)) << (8 * i));
    end
    if (!zext && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] d);
    logic [31:0] ai;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      ref_mem[ai] = 8'(d >> (8 * i));
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [1:0] op, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] ra,
                         input logic en, input int dly, input logic [31:0] exp_data,
                         input logic exp_en);
    vec_t v;
    v.name = name; v.op = op; v.w = w; v.a = a; v.d = d; v.ra = ra; v.en = en;
    v.dly = dly; v.exp_data = exp_data; v.exp_en = exp_en;
    vecs.push_back(v);
  endtask

  // One instruction through the stage; the bench acts as memory with dly wait cycles per byte
  task automatic run_txn(input string name, input logic [1:0] op, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] ra,
                         input logic en, input int dly, input logic [31:0] exp_data,
                         input logic exp_en, input bit scramble);
    int  n      = int'(w[2:0]);
    bit  valid  = (op == 2'd1 || op == 2'd2) && (n == 1 || n == 2 || n == 4);
    int  stalls = 0;
    int  k      = 0;
    int  waitc  = 0;
    int  cyc    = 0;
    bit  done   = 0;
    @(negedge clk);
    mem_op_i = op; width_i = w; mem_addr_i = a; rd_data_i = d;
    rd_addr_i = ra; rd_enable_i = en; mem_ready_i = 1'b0;
    #1;
    if (!valid) begin
      check({name, " pass data"},  rd_data_o,   d);
      check({name, " pass addr"},  32'(rd_addr_o), 32'(ra));
      check({name, " pass en"},    32'(rd_enable_o), 32'(en));
      check({name, " pass stall"}, 32'(stall_req_o), 32'd0);
      check({name, " pass req"},   32'(mem_req_o), 32'd0);
      return;
    end
    while (!done && cyc < 400) begin
      if (stall_req_o) begin
        stalls++;
        check({name, " en low while stalled"}, 32'(rd_enable_o), 32'd0);
        mem_ready_i = 1'b0;
        if (mem_req_o) begin
          check({name, " byte addr"}, mem_addr_o, a + 32'(k));
          check({name, " we"}, 32'(mem_we_o), 32'(op == 2'd2));
          if (op == 2'd2) check({name, " wdata"}, 32'(mem_wdata_o), 32'(8'(d >> (8 * k))));
          if (waitc == dly) begin
            mem_ready_i = 1'b1;
            if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
            else          mem_rdata_i = rd_mem(mem_addr_o);
            waitc = 0;
            k++;
          end else begin
            waitc++;
            mem_rdata_i = 8'($urandom);
          end
        end
        if (scramble && cyc == 1) begin
          mem_op_i = 2'($urandom); width_i = 4'($urandom); mem_addr_i = $urandom;
          rd_data_i = $urandom; rd_addr_i = 5'($urandom); rd_enable_i = 1'($urandom);
        end
        @(negedge clk);
        #1;
        cyc++;
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: stall still high after %0d cycles, expected release", name, cyc);
      return;
    end
    check({name, " stall cycles"}, 32'(stalls), 32'(1 + n * (dly + 1)));
    check({name, " done req"},  32'(mem_req_o), 32'd0);
    check({name, " done data"}, rd_data_o, exp_data);
    check({name, " done en"},   32'(rd_enable_o), 32'(exp_en));
    check({name, " done addr"}, 32'(rd_addr_o), 32'(ra));
  endtask

  initial begin
    logic [3:0] wsel [7];
    rst = 1'b0;
    mem_op_i = 2'd0; width_i = 4'd4; mem_addr_i = 32'h0; rd_data_i = 32'h1234;
    rd_addr_i = 5'd5; rd_enable_i = 1'b1; mem_ready_i = 1'b0; mem_rdata_i = 8'h0;
    #1;
    check("reset rd_data",  rd_data_o, 32'h0);
    check("reset rd_addr",  32'(rd_addr_o), 32'h0);
    check("reset rd_en",    32'(rd_enable_o), 32'h0);
    check("reset stall",    32'(stall_req_o), 32'h0);
    check("reset req",      32'(mem_req_o), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    poke(32'h1000, 8'h78); poke(32'h1001, 8'h56); poke(32'h1002, 8'h34); poke(32'h1003, 8'h12);
    poke(32'h2003, 8'h80);
    poke(32'h4000, 8'h34); poke(32'h4001, 8'hF2);
    poke(32'hFFFFFFFE, 8'h11); poke(32'hFFFFFFFF, 8'h22); poke(32'h0, 8'h33); poke(32'h1, 8'h44);

    add_vec("ADD pass",   2'd0, 4'h4, 32'h0,        32'h1234,     5'd5,  1'b1, 0, 32'h0,        1'b0);
    add_vec("LW",         2'd1, 4'h4, 32'h1000,     32'hDEADBEEF, 5'd7,  1'b1, 0, 32'h12345678, 1'b1);
    add_vec("LB",         2'd1, 4'h1, 32'h2003,     32'hDEADBEEF, 5'd8,  1'b1, 0, 32'hFFFFFF80, 1'b1);
    add_vec("LBU",        2'd1, 4'h9, 32'h2003,     32'hDEADBEEF, 5'd9,  1'b1, 0, 32'h00000080, 1'b1);
    add_vec("LH",         2'd1, 4'h2, 32'h4000,     32'hDEADBEEF, 5'd10, 1'b1, 0, 32'hFFFFF234, 1'b1);
    add_vec("SH",         2'd2, 4'h2, 32'h3001,     32'hAABBCCDD, 5'd11, 1'b1, 0, 32'h0,        1'b0);
    add_vec("SW slow",    2'd2, 4'h4, 32'h5000,     32'h11223344, 5'd12, 1'b1, 3, 32'h0,        1'b0);
    add_vec("LW wrap",    2'd1, 4'h4, 32'hFFFFFFFE, 32'h0,        5'd13, 1'b1, 1, 32'h44332211, 1'b1);
    add_vec("bad width",  2'd1, 4'h3, 32'h6000,     32'h0000CAFE, 5'd14, 1'b1, 0, 32'h0,        1'b0);
    add_vec("op 3",       2'd3, 4'h4, 32'h6000,     32'h00BEEF00, 5'd15, 1'b0, 0, 32'h0,        1'b0);
    add_vec("LW readback",2'd1, 4'h4, 32'h5000,     32'h0,        5'd16, 1'b0, 2, 32'h11223344, 1'b0);
    add_vec("LHU SH data",2'd1, 4'hA, 32'h3001,     32'h0,        5'd17, 1'b1, 0, 32'h0000CCDD, 1'b1);

    foreach (vecs[i]) begin
      run_txn(vecs[i].name, vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].ra,
              vecs[i].en, vecs[i].dly, vecs[i].exp_data, vecs[i].exp_en, 1'b0);
      if (vecs[i].op == 2'd2) ref_store(vecs[i].a, int'(vecs[i].w[2:0]), vecs[i].d);
    end
    check("SH byte @3001", 32'(rd_mem(32'h3001)), 32'hDD);
    check("SH byte @3002", 32'(rd_mem(32'h3002)), 32'hCC);
    check("SW byte @5003", 32'(rd_mem(32'h5003)), 32'h11);

    // Reset in the middle of a word load, then a stale ready while idle
    @(negedge clk);
    mem_op_i = 2'd1; width_i = 4'h4; mem_addr_i = 32'h7000; rd_data_i = 32'h0;
    rd_addr_i = 5'd3; rd_enable_i = 1'b1; mem_ready_i = 1'b0;
    @(negedge clk); #1;
    check("rst seq addr0", mem_addr_o, 32'h7000);
    mem_ready_i = 1'b1; mem_rdata_i = 8'hAA;
    @(negedge clk); #1;
    check("rst seq addr1", mem_addr_o, 32'h7001);
    mem_rdata_i = 8'hBB;
    @(negedge clk); #1;
    check("rst seq addr2", mem_addr_o, 32'h7002);
    rst = 1'b0;
    #1;
    check("rst mid req",   32'(mem_req_o), 32'd0);
    check("rst mid stall", 32'(stall_req_o), 32'd0);
    check("rst mid en",    32'(rd_enable_o), 32'd0);
    check("rst mid addr",  mem_addr_o, 32'h0);
    repeat (2) @(negedge clk);
    mem_op_i = 2'd0; rd_data_i = 32'h55; rd_addr_i = 5'd6; rd_enable_i = 1'b1;
    rst = 1'b1;
    #1;
    check("post rst pass", rd_data_o, 32'h55);
    check("post rst req",  32'(mem_req_o), 32'd0);
    @(negedge clk); #1;
    check("stale ready req",   32'(mem_req_o), 32'd0);
    check("stale ready stall", 32'(stall_req_o), 32'd0);
    mem_ready_i = 1'b0;
    run_txn("fresh LW", 2'd1, 4'h4, 32'h7000, 32'h0, 5'd3, 1'b1, 0,
            ref_load(32'h7000, 4, 1'b0), 1'b1, 1'b0);

    // Random traffic against the reference model
    wsel[0] = 4'h1; wsel[1] = 4'h2; wsel[2] = 4'h4; wsel[3] = 4'h9;
    wsel[4] = 4'hA; wsel[5] = 4'h3; wsel[6] = 4'hC;
    for (int t = 0; t < 60; t++) begin
      logic [1:0]  op  = 2'($urandom_range(0, 3));
      logic [3:0]  w   = wsel[$urandom_range(0, 6)];
      logic [31:0] a   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                                     : (32'h8000 + 32'($urandom_range(0, 63)));
      logic [31:0] d   = $urandom;
      logic [4:0]  ra  = 5'($urandom);
      logic        en  = 1'($urandom);
      int          dly = $urandom_range(0, 3);
      logic [31:0] ed  = 32'h0;
      logic        ee  = 1'b0;
      if (op == 2'd1) begin
        ed = ref_load(a, int'(w[2:0]), w[3]);
        ee = en;
      end
      run_txn("rand", op, w, a, d, ra, en, dly, ed, ee, 1'b1);
      if (op == 2'd2 && (w[2:0] == 3'd1 || w[2:0] == 3'd2 || w[2:0] == 3'd4))
        ref_store(a, int'(w[2:0]), d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
